// File: rtl/accum_pkg.sv
// ============================================================================
// Module      : accum_pkg
// Description : Shared types and widths for the accumulator control stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_pkg;

    localparam int ACC_W  = 16;
    localparam int OPND_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

endpackage : accum_pkg

`default_nettype wire

// File: rtl/accumulator_control.sv
// ============================================================================
// Module      : accumulator_control
// Description : Burst accumulator FSM and storage around an external Adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accumulator_control
    import accum_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_data,
    output logic [OPND_W-1:0] adder_operand,
    output logic [ACC_W-1:0]  adder_current,
    input  logic [ACC_W-1:0]  adder_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BURST_LEN);

    accum_state_t      state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs depend on state and clear only, never on in_valid/out_ready.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        acc_d = adder_sum;
                        cnt_d = cnt_inc;
                        // A wrapped modulo-2^16 sum is always smaller than the old total.
                        ovf_d = ovf_q | (adder_sum < acc_q);
                        if (cnt_inc == C_LAST) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = enable ? ACCUM : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign adder_operand = in_data;
    assign adder_current = acc_q;
    assign out_sum       = acc_q;
    assign out_count     = cnt_q;
    assign out_overflow  = ovf_q;

endmodule : accumulator_control

`default_nettype wire

// File: tb/tb_accumulator_control.sv
// ============================================================================
// Module      : tb_accumulator_control
// Description : Self-checking bench for accumulator_control (burst 4, 300, 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accumulator_control;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- BURST_LEN = 4 instance ----------------
    logic        a_en, a_clr, a_iv, a_ir, a_ov, a_ordy, a_ovf;
    logic [7:0]  a_d, a_op;
    logic [15:0] a_cur, a_asum, a_sum;
    logic [2:0]  a_cnt;
    assign a_asum = a_cur + {8'h00, a_op};

    accumulator_control #(.BURST_LEN(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(a_en), .clear(a_clr),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
        .adder_operand(a_op), .adder_current(a_cur), .adder_sum(a_asum),
        .out_valid(a_ov), .out_ready(a_ordy), .out_sum(a_sum),
        .out_count(a_cnt), .out_overflow(a_ovf)
    );

    // ---------------- BURST_LEN = 300 instance ----------------
    logic        b_en, b_clr, b_iv, b_ir, b_ov, b_ordy, b_ovf;
    logic [7:0]  b_d, b_op;
    logic [15:0] b_cur, b_asum, b_sum;
    logic [8:0]  b_cnt;
    assign b_asum = b_cur + {8'h00, b_op};

    accumulator_control #(.BURST_LEN(300)) dut300 (
        .clk(clk), .reset_n(reset_n), .enable(b_en), .clear(b_clr),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
        .adder_operand(b_op), .adder_current(b_cur), .adder_sum(b_asum),
        .out_valid(b_ov), .out_ready(b_ordy), .out_sum(b_sum),
        .out_count(b_cnt), .out_overflow(b_ovf)
    );

    // ---------------- BURST_LEN = 1 instance ----------------
    logic        c_en, c_clr, c_iv, c_ir, c_ov, c_ordy, c_ovf;
    logic [7:0]  c_d, c_op;
    logic [15:0] c_cur, c_asum, c_sum;
    logic [0:0]  c_cnt;
    assign c_asum = c_cur + {8'h00, c_op};

    accumulator_control #(.BURST_LEN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(c_en), .clear(c_clr),
        .in_valid(c_iv), .in_ready(c_ir), .in_data(c_d),
        .adder_operand(c_op), .adder_current(c_cur), .adder_sum(c_asum),
        .out_valid(c_ov), .out_ready(c_ordy), .out_sum(c_sum),
        .out_count(c_cnt), .out_overflow(c_ovf)
    );

    typedef struct {
        logic        en, clr, iv;
        logic [7:0]  d;
        logic        ordy;
        logic        ir, ov;
        logic [15:0] sum;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic clr, input logic iv, input logic [7:0] d,
                       input logic ordy, input logic ir, input logic ov,
                       input logic [15:0] sum, input logic [2:0] cnt);
        vec_t v;
        v.en = en; v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.sum = sum; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        a_en = 0; a_clr = 0; a_iv = 0; a_d = 0; a_ordy = 0;
        b_en = 0; b_clr = 0; b_iv = 0; b_d = 0; b_ordy = 0;
        c_en = 0; c_clr = 0; c_iv = 0; c_d = 0; c_ordy = 0;

        // Expected state after each clock edge, with that row's inputs still applied.
        add(0,0,0,8'h00,0, 0,0,16'h0000,0);
        add(1,0,0,8'h00,0, 1,0,16'h0000,0);
        add(1,0,1,8'h10,0, 1,0,16'h0010,1);
        add(1,0,1,8'h20,0, 1,0,16'h0030,2);
        add(1,0,1,8'h30,0, 1,0,16'h0060,3);
        add(1,0,1,8'h40,0, 0,1,16'h00A0,4);
        for (int i = 0; i < 5; i++) add(1,0,1,8'h99,0, 0,1,16'h00A0,4);
        add(1,0,0,8'h00,1, 1,0,16'h0000,0);
        add(1,0,1,8'h01,0, 1,0,16'h0001,1);
        add(1,0,0,8'h01,0, 1,0,16'h0001,1);
        add(1,0,1,8'h01,0, 1,0,16'h0002,2);
        add(1,0,0,8'h01,0, 1,0,16'h0002,2);
        add(1,0,1,8'h01,0, 1,0,16'h0003,3);
        add(1,0,0,8'h01,0, 1,0,16'h0003,3);
        add(1,0,1,8'h01,0, 0,1,16'h0004,4);
        add(0,0,0,8'h00,1, 0,0,16'h0000,0);
        add(1,0,0,8'h00,0, 1,0,16'h0000,0);
        add(1,0,1,8'h05,0, 1,0,16'h0005,1);
        add(1,0,1,8'h07,0, 1,0,16'h000C,2);
        add(1,1,1,8'h09,0, 0,0,16'h0000,0);
        add(0,0,0,8'h00,0, 0,0,16'h0000,0);
        add(1,0,0,8'h00,0, 1,0,16'h0000,0);
        add(1,0,1,8'h01,0, 1,0,16'h0001,1);
        add(1,0,1,8'h01,0, 1,0,16'h0002,2);
        add(1,0,1,8'h01,0, 1,0,16'h0003,3);
        add(1,0,1,8'h01,0, 0,1,16'h0004,4);
        add(0,0,0,8'h00,1, 0,0,16'h0000,0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", a_ir, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_sum", a_sum, 0);
        chk("rst_out_count", a_cnt, 0);
        chk("rst_adder_current", a_cur, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven run on the BURST_LEN=4 instance
        foreach (vecs[i]) begin
            a_en = vecs[i].en; a_clr = vecs[i].clr; a_iv = vecs[i].iv;
            a_d = vecs[i].d; a_ordy = vecs[i].ordy;
            tick();
            chk($sformatf("v%0d_in_ready", i), a_ir, vecs[i].ir);
            chk($sformatf("v%0d_out_valid", i), a_ov, vecs[i].ov);
            chk($sformatf("v%0d_out_sum", i), a_sum, vecs[i].sum);
            chk($sformatf("v%0d_adder_current", i), a_cur, vecs[i].sum);
            chk($sformatf("v%0d_out_count", i), a_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_out_overflow", i), a_ovf, 0);
        end

        // Async reset mid-burst on the BURST_LEN=300 instance
        b_en = 1; tick();
        b_iv = 1; b_d = 8'hFF;
        repeat (10) tick();
        chk("b300_mid_sum", b_sum, 16'h09F6);
        chk("b300_mid_cnt", b_cnt, 10);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_mid_sum", b_sum, 0);
        chk("arst_mid_cnt", b_cnt, 0);
        chk("arst_mid_in_ready", b_ir, 0);
        chk("arst_mid_adder_current", b_cur, 0);
        b_en = 0; b_iv = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle_in_ready", b_ir, 0);

        // 300 x 0xFF with wrap
        b_en = 1; tick();
        chk("b300_accum_ready", b_ir, 1);
        b_iv = 1; b_d = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            if (i < 299 && b_ir !== 1'b1) chk("b300_no_bubble", b_ir, 1);
            tick();
        end
        b_iv = 0;
        chk("b300_out_valid", b_ov, 1);
        chk("b300_out_sum", b_sum, 16'h2AD4);
        chk("b300_out_count", b_cnt, 300);
        chk("b300_out_overflow", b_ovf, 1);
        b_en = 0; b_ordy = 1; tick();
        chk("b300_after_accept_valid", b_ov, 0);
        chk("b300_after_accept_ovf", b_ovf, 0);
        b_ordy = 0;

        // BURST_LEN=1: single accept goes straight to DONE, then async reset in DONE
        c_en = 1; tick();
        c_iv = 1; c_d = 8'h37; tick();
        c_iv = 0;
        chk("b1_out_valid", c_ov, 1);
        chk("b1_out_sum", c_sum, 16'h0037);
        chk("b1_out_count", c_cnt, 1);
        chk("b1_in_ready_done", c_ir, 0);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_done_out_valid", c_ov, 0);
        chk("arst_done_out_sum", c_sum, 0);
        chk("arst_done_out_count", c_cnt, 0);
        c_en = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("b1_idle_holds", c_ir, 0);
        c_en = 1; tick();
        chk("b1_enable_to_accum", c_ir, 1);
        c_clr = 1; c_iv = 1; c_d = 8'h22;
        #1;
        chk("clear_forces_in_ready_low", c_ir, 0);
        tick();
        c_clr = 0; c_iv = 0; c_en = 0;
        #1;
        chk("clear_to_idle_ready", c_ir, 0);
        chk("clear_no_accept_sum", c_sum, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_accumulator_control

`default_nettype wire
